regread_stage: RTL and testbench

- Operand-fetch pipeline stage directly upstream of the 2-read/1-write register file.
- Accepts decoded register indices from decode and drives both read addresses.
- Tracks in-flight destination registers with a busy-bit scoreboard and stalls on RAW/WAW hazards.
- Bypasses same-cycle writeback data, then registers operands toward execute behind a valid/ready handshake.

---
 rtl/regread_pkg.sv | 21 ++
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/regread_stage.sv | 111 +++++++++++
 tb/tb_regread_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regread_pkg.sv
// Shared types and constants for the operand-fetch stage and its busy-bit scoreboard.
// The execute-side bundle is sized by the package defaults; module parameters must match them.
package regread_pkg;

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int REG_FILE_SIZE_DEF = 32;
   localparam int ADDR_WIDTH_DEF    = addr_width(REG_FILE_SIZE_DEF);
   localparam int REG_ZERO          = 0;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] op1;
      logic [DATA_WIDTH_DEF-1:0] op2;
      logic [ADDR_WIDTH_DEF-1:0] rd;
      logic                      rd_wen;
   } regread_out_t;

endpackage

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register; lookups see a same-cycle writeback as already clear.
module reg_scoreboard
   import regread_pkg::*;
#(
   parameter int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
   parameter int ADDR_WIDTH    = addr_width(REG_FILE_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic [ADDR_WIDTH-1:0] lk1_addr,
   input  logic [ADDR_WIDTH-1:0] lk2_addr,
   input  logic [ADDR_WIDTH-1:0] lk3_addr,
   output logic                  lk1_busy,
   output logic                  lk2_busy,
   output logic                  lk3_busy
);

   logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
   logic [REG_FILE_SIZE-1:0] set_vec, clr_vec, eff_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en) set_vec[set_addr] = 1'b1;
      if (clr_en) clr_vec[clr_addr] = 1'b1;
      set_vec[REG_ZERO] = 1'b0;
      clr_vec[REG_ZERO] = 1'b0;
      eff_vec = busy_q & ~clr_vec;
      // Set is applied after clear so a re-issued destination stays busy.
      busy_d  = eff_vec | set_vec;
   end

   assign lk1_busy = eff_vec[lk1_addr];
   assign lk2_busy = eff_vec[lk2_addr];
   assign lk3_busy = eff_vec[lk3_addr];

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

endmodule

// File: rtl/regread_stage.sv
// Operand-fetch stage: drives regfile reads, stalls on RAW/WAW hazards, bypasses writeback data
// and registers the resolved operands toward execute behind a valid/ready handshake.
module regread_stage
   import regread_pkg::*;
#(
   parameter  int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter  int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
   localparam int ADDR_WIDTH    = addr_width(REG_FILE_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_rs1,
   input  logic [ADDR_WIDTH-1:0] i_rs2,
   input  logic [ADDR_WIDTH-1:0] i_rd,
   input  logic                  i_rd_wen,
   output logic [ADDR_WIDTH-1:0] o_raddr1,
   output logic [ADDR_WIDTH-1:0] o_raddr2,
   input  logic [DATA_WIDTH-1:0] i_rdata1,
   input  logic [DATA_WIDTH-1:0] i_rdata2,
   input  logic                  i_wb_valid,
   input  logic [ADDR_WIDTH-1:0] i_wb_addr,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_op1,
   output logic [DATA_WIDTH-1:0] o_op2,
   output logic [ADDR_WIDTH-1:0] o_rd,
   output logic                  o_rd_wen
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic         busy_rs1, busy_rs2, busy_rd;
   logic         hazard, accept;
   logic         valid_q, valid_d;
   regread_out_t out_q, out_d;

   // The regfile writes on the same edge, so its read of a writeback target is stale.
   function automatic logic [DATA_WIDTH-1:0] resolve(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic [DATA_WIDTH-1:0] rdata,
      input logic                  wb_valid,
      input logic [ADDR_WIDTH-1:0] wb_addr,
      input logic [DATA_WIDTH-1:0] wb_data
   );
      if (idx == ZERO_IDX)                return '0;
      else if (wb_valid && wb_addr == idx) return wb_data;
      else                                 return rdata;
   endfunction

   assign o_raddr1 = i_rs1;
   assign o_raddr2 = i_rs2;

   reg_scoreboard #(
      .REG_FILE_SIZE (REG_FILE_SIZE),
      .ADDR_WIDTH    (ADDR_WIDTH)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (accept & i_rd_wen),
      .set_addr (i_rd),
      .clr_en   (i_wb_valid),
      .clr_addr (i_wb_addr),
      .lk1_addr (i_rs1),
      .lk2_addr (i_rs2),
      .lk3_addr (i_rd),
      .lk1_busy (busy_rs1),
      .lk2_busy (busy_rs2),
      .lk3_busy (busy_rd)
   );

   always_comb begin
      hazard  = busy_rs1 | busy_rs2 | (i_rd_wen & busy_rd);
      o_ready = ~hazard & (~valid_q | i_ready);
      accept  = i_valid & o_ready;
   end

   // NOTE: defaults first keep this block free of inferred latches on every path.
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      if (accept) begin
         out_d.op1    = resolve(i_rs1, i_rdata1, i_wb_valid, i_wb_addr, i_wb_data);
         out_d.op2    = resolve(i_rs2, i_rdata2, i_wb_valid, i_wb_addr, i_wb_data);
         out_d.rd     = i_rd;
         out_d.rd_wen = i_rd_wen;
         valid_d      = 1'b1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_op1    = out_q.op1;
   assign o_op2    = out_q.op2;
   assign o_rd     = out_q.rd;
   assign o_rd_wen = out_q.rd_wen;

endmodule

// File: tb/tb_regread_stage.sv
// Directed bench for regread_stage: stimulus pushes hand-computed results into a queue,
// a monitor pops and compares whenever execute takes a valid output.
module tb_regread_stage;
   import regread_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk, rst;
   logic          i_valid, o_ready;
   logic [AW-1:0] i_rs1, i_rs2, i_rd;
   logic          i_rd_wen;
   logic [AW-1:0] o_raddr1, o_raddr2;
   logic [DW-1:0] i_rdata1, i_rdata2;
   logic          i_wb_valid;
   logic [AW-1:0] i_wb_addr;
   logic [DW-1:0] i_wb_data;
   logic          o_valid, i_ready;
   logic [DW-1:0] o_op1, o_op2;
   logic [AW-1:0] o_rd;
   logic          o_rd_wen;

   logic [DW-1:0] rf [32];
   regread_out_t  exp_q [$];
   int            pass_cnt = 0;
   int            chk_cnt  = 0;

   regread_stage dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .i_rd       (i_rd),
      .i_rd_wen   (i_rd_wen),
      .o_raddr1   (o_raddr1),
      .o_raddr2   (o_raddr2),
      .i_rdata1   (i_rdata1),
      .i_rdata2   (i_rdata2),
      .i_wb_valid (i_wb_valid),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_op1      (o_op1),
      .o_op2      (o_op2),
      .o_rd       (o_rd),
      .o_rd_wen   (o_rd_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: combinational read, write on the clock edge; x0 deliberately non-zero.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
         rf[0] <= 32'hBAD0_0000;
         rf[1] <= 32'd5;
         rf[2] <= 32'd7;
         rf[4] <= 32'hDEAD_0004;
      end else if (i_wb_valid && i_wb_addr != 0) begin
         rf[i_wb_addr] <= i_wb_data;
      end
   end

   always_comb begin
      i_rdata1 = rf[o_raddr1];
      i_rdata2 = rf[o_raddr2];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            regread_out_t e;
            e = exp_q.pop_front();
            check("op1", o_op1, e.op1);
            check("op2", o_op2, e.op2);
            check("rd", 32'(o_rd), 32'(e.rd));
            check("rd_wen", 32'(o_rd_wen), 32'(e.rd_wen));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [AW-1:0] rs1, rs2, rd, input logic wen);
      i_valid  = 1'b1;
      i_rs1    = rs1;
      i_rs2    = rs2;
      i_rd     = rd;
      i_rd_wen = wen;
   endtask

   task automatic set_wb(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      i_wb_valid = 1'b1;
      i_wb_addr  = addr;
      i_wb_data  = data;
   endtask

   task automatic expect_stall(input string name, input int n);
      repeat (n) begin
         @(negedge clk);
         check(name, 32'(o_ready), 32'd0);
         step();
      end
   endtask

   // Expects the driven instruction to be accepted this cycle and queues its result.
   task automatic release_instr(input string name, input logic [DW-1:0] e1, e2);
      regread_out_t e;
      @(negedge clk);
      check(name, 32'(o_ready), 32'd1);
      check("raddr1", 32'(o_raddr1), 32'(i_rs1));
      check("raddr2", 32'(o_raddr2), 32'(i_rs2));
      e.op1    = e1;
      e.op2    = e2;
      e.rd     = i_rd;
      e.rd_wen = i_rd_wen;
      exp_q.push_back(e);
      step();
      i_valid    = 1'b0;
      i_wb_valid = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] rs1, rs2, rd, input logic wen,
                        input logic [DW-1:0] e1, e2);
      drive(rs1, rs2, rd, wen);
      release_instr("ready", e1, e2);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_rd_wen = 1'b0;
      i_wb_valid = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_ready = 1'b1;
      step();
      step();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_op1", o_op1, 32'd0);
      check("rst_op2", o_op2, 32'd0);
      check("rst_rd", 32'(o_rd), 32'd0);
      check("rst_rd_wen", 32'(o_rd_wen), 32'd0);
      rst = 1'b0;
      step();

      // Independent back-to-back stream
      issue(5'd1, 5'd2, 5'd8,  1'b1, 32'd5, 32'd7);
      issue(5'd1, 5'd2, 5'd9,  1'b1, 32'd5, 32'd7);
      issue(5'd1, 5'd2, 5'd10, 1'b1, 32'd5, 32'd7);

      // RAW stall released by bypassed writeback
      issue(5'd1, 5'd2, 5'd4, 1'b1, 32'd5, 32'd7);
      drive(5'd4, 5'd0, 5'd11, 1'b1);
      expect_stall("raw_stall", 3);
      set_wb(5'd4, 32'h1234);
      release_instr("raw_release", 32'h1234, 32'd0);
      issue(5'd4, 5'd4, 5'd0, 1'b0, 32'h1234, 32'h1234);

      // WAW stall; release coincides with writeback, set must win
      issue(5'd1, 5'd2, 5'd6, 1'b1, 32'd5, 32'd7);
      drive(5'd1, 5'd2, 5'd6, 1'b1);
      expect_stall("waw_stall", 2);
      set_wb(5'd6, 32'h66);
      release_instr("waw_release", 32'd5, 32'd7);
      drive(5'd6, 5'd1, 5'd12, 1'b1);
      expect_stall("set_wins_stall", 2);
      set_wb(5'd6, 32'h6606);
      release_instr("second_wb_release", 32'h6606, 32'd5);

      // Register zero and spurious writeback forwarding
      issue(5'd0, 5'd1, 5'd0, 1'b1, 32'd0, 32'd5);
      set_wb(5'd0, 32'hFFFF_FFFF);
      issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
      set_wb(5'd2, 32'h77);
      issue(5'd2, 5'd1, 5'd0, 1'b0, 32'h77, 32'd5);

      // Backpressure: outputs hold for three cycles
      step();
      step();
      i_ready = 1'b0;
      issue(5'd1, 5'd0, 5'd13, 1'b0, 32'd5, 32'd0);
      drive(5'd1, 5'd1, 5'd15, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("bp_valid", 32'(o_valid), 32'd1);
         check("bp_op1", o_op1, 32'd5);
         check("bp_op2", o_op2, 32'd0);
         check("bp_rd", 32'(o_rd), 32'd13);
         check("bp_ready", 32'(o_ready), 32'd0);
         step();
      end
      i_ready = 1'b1;
      release_instr("bp_release", 32'd5, 32'd5);

      // Async reset with a held output and busy[5] set
      issue(5'd1, 5'd1, 5'd5, 1'b1, 32'd5, 32'd5);
      i_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_op1", o_op1, 32'd0);
      check("arst_rd", 32'(o_rd), 32'd0);
      exp_q.delete();
      step();
      rst = 1'b0;
      i_ready = 1'b1;
      issue(5'd5, 5'd0, 5'd14, 1'b1, 32'h105, 32'd0);

      step();
      step();
      step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
